// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, raster state types and sync bundle for the VGA path.
package vga_timing_pkg;

  // Default 800x600@72 Hz raster, 50 MHz pixel clock
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 56;
  localparam int unsigned DEF_H_SYNC   = 120;
  localparam int unsigned DEF_H_BP     = 64;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 37;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 23;
  localparam int unsigned DEF_PIPE_DLY = 1;

  localparam int unsigned X_W          = 11;
  localparam int unsigned Y_W          = 10;
  localparam int unsigned COLOR_W      = 6;
  localparam int unsigned MAX_H_TOTAL  = 2048;
  localparam int unsigned MAX_V_TOTAL  = 1024;
  localparam int unsigned MAX_PIPE_DLY = 4;

  typedef enum logic [1:0] {HS_ACT, HS_FRONT, HS_SYNC, HS_BACK} h_state_e;
  typedef enum logic [1:0] {VS_ACT, VS_FRONT, VS_SYNC, VS_BACK} v_state_e;

  // Undelayed raster flags carried through the delay line
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_bits_t;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-qualified shift register that delay-matches sync/blank to the colour pipeline.
module vga_sync_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    // Shift one stage per enabled pixel; reset clears every stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= '0;
      end else if (en) begin
        sr[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster sequencer: h/v counters and FSMs, delay-matched sync/blank, gated registered colour.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        H_POL    = 1'b1,
  parameter logic        V_POL    = 1'b1,
  parameter int unsigned PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  input  logic [COLOR_W-1:0] color_in,
  output logic [COLOR_W-1:0] color_out,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned H_FRONT_X = H_ACTIVE;
  localparam int unsigned H_SYNC_X  = H_ACTIVE + H_FP;
  localparam int unsigned H_BACK_X  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_FRONT_Y = V_ACTIVE;
  localparam int unsigned V_SYNC_Y  = V_ACTIVE + V_FP;
  localparam int unsigned V_BACK_Y  = V_ACTIVE + V_FP + V_SYNC;

  if (H_TOTAL > MAX_H_TOTAL) begin : g_bad_h_total
    $error("vga_timing_ctrl: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > MAX_V_TOTAL) begin : g_bad_v_total
    $error("vga_timing_ctrl: V_TOTAL exceeds 1024");
  end
  if (PIPE_DLY > MAX_PIPE_DLY) begin : g_bad_pipe_dly
    $error("vga_timing_ctrl: PIPE_DLY exceeds 4");
  end

  h_state_e       hstate, hstate_nxt;
  v_state_e       vstate, vstate_nxt;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           x_wrap;
  sync_bits_t     raw_bits;
  sync_bits_t     dly_bits;

  // Next counts and FSM transitions; states move on the same edge x/y cross a boundary
  always_comb begin
    x_nxt      = x + X_W'(1);
    y_nxt      = y;
    x_wrap     = 1'b0;
    hstate_nxt = hstate;
    vstate_nxt = vstate;

    if (x == X_W'(H_TOTAL - 1)) begin
      x_nxt  = '0;
      x_wrap = 1'b1;
      y_nxt  = (y == Y_W'(V_TOTAL - 1)) ? '0 : y + Y_W'(1);
    end

    case (hstate)
      HS_ACT:   if (x_nxt == X_W'(H_FRONT_X)) hstate_nxt = HS_FRONT;
      HS_FRONT: if (x_nxt == X_W'(H_SYNC_X))  hstate_nxt = HS_SYNC;
      HS_SYNC:  if (x_nxt == X_W'(H_BACK_X))  hstate_nxt = HS_BACK;
      HS_BACK:  if (x_wrap)                   hstate_nxt = HS_ACT;
      default:                                hstate_nxt = HS_ACT;
    endcase

    if (x_wrap) begin
      case (vstate)
        VS_ACT:   if (y_nxt == Y_W'(V_FRONT_Y)) vstate_nxt = VS_FRONT;
        VS_FRONT: if (y_nxt == Y_W'(V_SYNC_Y))  vstate_nxt = VS_SYNC;
        VS_SYNC:  if (y_nxt == Y_W'(V_BACK_Y))  vstate_nxt = VS_BACK;
        VS_BACK:  if (y_nxt == '0)              vstate_nxt = VS_ACT;
        default:                                vstate_nxt = VS_ACT;
      endcase
    end
  end

  // Counter/state registers plus start pulses decoded from the next count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      hstate      <= HS_ACT;
      vstate      <= VS_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= en & (x_nxt == '0);
      frame_start <= en & (x_nxt == '0) & (y_nxt == '0);
      if (en) begin
        x      <= x_nxt;
        y      <= y_nxt;
        hstate <= hstate_nxt;
        vstate <= vstate_nxt;
      end
    end
  end

  assign raw_bits.active = (hstate == HS_ACT) && (vstate == VS_ACT);
  assign raw_bits.hs     = (hstate == HS_SYNC);
  assign raw_bits.vs     = (vstate == VS_SYNC);

  vga_sync_delay #(
    .WIDTH ($bits(sync_bits_t)),
    .DEPTH (PIPE_DLY)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (raw_bits),
    .dout (dly_bits)
  );

  // Pin register: all four DAC-side outputs leave together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank     <= 1'b1;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      color_out <= '0;
    end else if (en) begin
      blank     <= ~dly_bits.active;
      hsync     <= dly_bits.hs ? H_POL : ~H_POL;
      vsync     <= dly_bits.vs ? V_POL : ~V_POL;
      color_out <= dly_bits.active ? color_in : '0;
    end
  end

endmodule
